wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Writer-side companion to the register file: accepts results from the ALU and load/memory paths and drives the file's single write port (RegWrite / WriteAddr / Data).
- Results are serialized to at most one register write per cycle. ALU results are buffered in a small FIFO while load results take the port.
- Maintains a pending-destination scoreboard so issue logic can stall on registers whose results have not yet been written.

Parameters:
- DEPTH, 4, ALU result FIFO entries (power of 2, >=2)
- CW, 3, width of out_FifoCount; must hold 0..DEPTH

Ports:
- CLK  in  1  clock
- RST  in  1  reset; synchronous, active-high
- in_AluValid  in  1  ALU result offered this cycle
- out_AluReady  out  1  ALU result accepted when valid & ready
- in_AluAddr  in  4  ALU destination register
- in_AluData  in  16  ALU result
- in_MemValid  in  1  load result present; always accepted, no backpressure
- in_MemAddr  in  4  load destination register
- in_MemData  in  16  load result
- in_IssueValid  in  1  instruction issued with a destination
- in_IssueAddr  in  4  issued destination register
- out_RegWrite  out  1  register file write enable (registered)
- out_WriteAddr  out  4  register file write address (registered)
- out_Data  out  16  register file write data (registered)
- out_Pending  out  16  bit n = register n has an outstanding result
- out_FifoCount  out  CW  current ALU FIFO occupancy

Behaviour:
- Reset (at the CLK edge with RST=1):
  - FIFO emptied; count=0.
  - out_RegWrite=0, out_WriteAddr=0, out_Data=0, out_Pending=0.
  - Inputs presented in a reset cycle are dropped.
  - out_AluReady=0 while RST=1.
  - Reset mid-operation discards all queued results without writing them.
- out_AluReady = !RST && (count < DEPTH). This is combinational from the registered count. A pop in the same cycle does not raise ready when full.
- Write-port selection per cycle, in priority order:
  1. in_MemValid=1: the load result drives the port at the next edge. Any offered ALU result is enqueued if ready.
  2. Otherwise, if the FIFO is non-empty: pop the head and drive the port. An offered ALU result is enqueued if ready (simultaneous push/pop, count unchanged).
  3. Otherwise, if the FIFO is empty and in_AluValid=1: bypass. The ALU result drives the port at the next edge and is not enqueued.
  4. Otherwise: out_RegWrite=0 at the next edge. out_WriteAddr and out_Data hold their previous values.
- Latency:
  - Load result: 1 cycle.
  - ALU bypass: 1 cycle.
  - Queued ALU result: one cycle after it reaches the head with no load competing.
- Load traffic on every cycle starves the FIFO indefinitely. This is by design: the pipeline guarantees load gaps.
- FIFO ordering is strict: ALU results are written in acceptance order.
- Register 0:
  - A selected result with address 0 is consumed (popped or accepted) but produces out_RegWrite=0.
  - in_IssueValid with address 0 is ignored.
  - out_Pending[0] is always 0.
- Scoreboard:
  - Bit n is set at the edge where in_IssueValid=1 and in_IssueAddr=n (n!=0).
  - Bit n is cleared at the edge where a result for n is registered onto the write port.
  - Set and clear of the same bit at the same edge: set wins, because the issue is the newer producer.
  - Issues on different registers are independent; multiple bits may be set.
- Counter wrap: FIFO read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count does not wrap: pushes are refused when full.
- Data is passed through unmodified (16-bit, no sign handling).

Test Plan:
- Reset: assert RST 2 cycles with in_MemValid=1 -> out_RegWrite=0, out_Pending=0, out_FifoCount=0, out_AluReady=0. After release, out_AluReady=1.
- Bypass: FIFO empty, ALU valid addr=5 data=0x1234 -> next cycle out_RegWrite=1, out_WriteAddr=5, out_Data=0x1234, out_FifoCount stays 0.
- Contention:
  - Same cycle: mem addr=3 data=0x00AA and ALU addr=4 data=0x00BB.
  - Expected: cycle+1 writes r3=0x00AA, count=1; cycle+2 writes r4=0x00BB, count=0.
- Full/backpressure:
  - Hold in_MemValid=1 (addr=7) for 6 cycles while offering ALU results 0x0001..0x0006 to r8.
  - Expected: ready drops after 4 accepts (count=4). Results 1..4 are written in order once mem deasserts; items 5 and 6 are accepted only after ready returns.
- r0 handling: mem result addr=0 data=0xFFFF, then issue addr=0 -> out_RegWrite stays 0, out_Pending[0]=0.
- Scoreboard:
  - Issue r9, then the ALU result for r9 is written -> out_Pending[9] set one edge after issue and cleared at the write edge.
  - Issue r9 in the same cycle the r9 result is selected -> out_Pending[9] remains 1.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Signal bundle between the result producers / issue logic and wb_arbiter,
// including the register-file write port it drives.
interface wb_arbiter_if #(
    parameter int unsigned CW = 3
);
    logic          in_AluValid;
    logic          out_AluReady;
    logic [3:0]    in_AluAddr;
    logic [15:0]   in_AluData;
    logic          in_MemValid;
    logic [3:0]    in_MemAddr;
    logic [15:0]   in_MemData;
    logic          in_IssueValid;
    logic [3:0]    in_IssueAddr;
    logic          out_RegWrite;
    logic [3:0]    out_WriteAddr;
    logic [15:0]   out_Data;
    logic [15:0]   out_Pending;
    logic [CW-1:0] out_FifoCount;

    modport master (
        output in_AluValid, in_AluAddr, in_AluData,
        output in_MemValid, in_MemAddr, in_MemData,
        output in_IssueValid, in_IssueAddr,
        input  out_AluReady, out_RegWrite, out_WriteAddr, out_Data,
        input  out_Pending, out_FifoCount
    );

    modport slave (
        input  in_AluValid, in_AluAddr, in_AluData,
        input  in_MemValid, in_MemAddr, in_MemData,
        input  in_IssueValid, in_IssueAddr,
        output out_AluReady, out_RegWrite, out_WriteAddr, out_Data,
        output out_Pending, out_FifoCount
    );
endinterface

// File: rtl/wb_arbiter.sv
// Serializes load and ALU results onto the single register-file write port,
// buffering ALU results in a FIFO and tracking pending destinations.
module wb_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = 3
) (
    input  logic       CLK,
    input  logic       RST,
    wb_arbiter_if.slave bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [3:0]  addr;
        logic [15:0] data;
    } result_t;

    result_t       fifo [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          fifo_empty;
    logic          ready;
    logic          push;
    logic          pop;
    logic          sel_valid;
    result_t       sel;
    result_t       alu_res;
    logic          write_en;
    logic [15:0]   pending;
    logic [15:0]   pending_next;
    logic          write_reg;
    logic [3:0]    write_addr;
    logic [15:0]   write_data;

    assign fifo_empty   = (count == '0);
    assign ready        = !RST && (count < CW'(DEPTH));
    assign alu_res.addr = bus.in_AluAddr;
    assign alu_res.data = bus.in_AluData;

    // Priority: load, then FIFO head, then ALU bypass when the FIFO is empty.
    always_comb begin
        sel_valid = 1'b0;
        sel       = '0;
        push      = 1'b0;
        pop       = 1'b0;
        if (bus.in_MemValid) begin
            sel_valid = 1'b1;
            sel.addr  = bus.in_MemAddr;
            sel.data  = bus.in_MemData;
            push      = bus.in_AluValid && ready;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel       = fifo[rd_ptr];
            pop       = 1'b1;
            push      = bus.in_AluValid && ready;
        end else if (bus.in_AluValid) begin
            sel_valid = 1'b1;
            sel       = alu_res;
        end
    end

    // Register 0 results are consumed but never written.
    assign write_en = sel_valid && (sel.addr != '0);

    // A same-edge issue overrides the clear: the issue is the newer producer.
    always_comb begin
        pending_next = pending;
        if (write_en) begin
            pending_next[sel.addr] = 1'b0;
        end
        if (bus.in_IssueValid && (bus.in_IssueAddr != '0)) begin
            pending_next[bus.in_IssueAddr] = 1'b1;
        end
        pending_next[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (push && !RST) begin
            fifo[wr_ptr] <= alu_res;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            write_reg  <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            pending    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            write_reg <= write_en;
            if (write_en) begin
                write_addr <= sel.addr;
                write_data <= sel.data;
            end
            pending <= pending_next;
        end
    end

    assign bus.out_AluReady  = ready;
    assign bus.out_RegWrite  = write_reg;
    assign bus.out_WriteAddr = write_addr;
    assign bus.out_Data      = write_data;
    assign bus.out_Pending   = pending;
    assign bus.out_FifoCount = count;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed and random stimulus for wb_arbiter, checked cycle by cycle against
// a queue-based reference model of the write-port selection rules.
module tb_wb_arbiter;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;

    logic CLK = 1'b0;
    logic RST;

    wb_arbiter_if #(.CW(CW)) bus ();

    wb_arbiter #(.DEPTH(DEPTH), .CW(CW)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: queue of {addr, data}, expected port and scoreboard.
    logic [19:0] q [$];
    logic        m_we;
    logic [3:0]  m_wa;
    logic [15:0] m_wd;
    logic [15:0] m_pend;
    logic        last_accept;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.in_AluValid   = 1'b0;
        bus.in_AluAddr    = '0;
        bus.in_AluData    = '0;
        bus.in_MemValid   = 1'b0;
        bus.in_MemAddr    = '0;
        bus.in_MemData    = '0;
        bus.in_IssueValid = 1'b0;
        bus.in_IssueAddr  = '0;
    endtask

    // Applies the current inputs for one clock and checks the DUT against the model.
    task automatic tick();
        logic        exp_ready;
        logic        has;
        logic        bypass;
        logic [3:0]  a;
        logic [15:0] d;
        #1;
        exp_ready = !RST && (q.size() < DEPTH);
        check("alu_ready", 32'(bus.out_AluReady), 32'(exp_ready));
        last_accept = bus.in_AluValid && exp_ready;
        if (RST) begin
            q.delete();
            m_we   = 1'b0;
            m_wa   = '0;
            m_wd   = '0;
            m_pend = '0;
        end else begin
            has    = 1'b0;
            bypass = 1'b0;
            a      = '0;
            d      = '0;
            if (bus.in_MemValid) begin
                has = 1'b1;
                a   = bus.in_MemAddr;
                d   = bus.in_MemData;
            end else if (q.size() != 0) begin
                {a, d} = q.pop_front();
                has    = 1'b1;
            end else if (bus.in_AluValid) begin
                has    = 1'b1;
                bypass = 1'b1;
                a      = bus.in_AluAddr;
                d      = bus.in_AluData;
            end
            if (last_accept && !bypass) begin
                q.push_back({bus.in_AluAddr, bus.in_AluData});
            end
            m_we = has && (a != 4'd0);
            if (m_we) begin
                m_wa       = a;
                m_wd       = d;
                m_pend[a]  = 1'b0;
            end
            if (bus.in_IssueValid && bus.in_IssueAddr != 4'd0) begin
                m_pend[bus.in_IssueAddr] = 1'b1;
            end
        end
        @(posedge CLK);
        #1;
        check("reg_write",  32'(bus.out_RegWrite),  32'(m_we));
        check("write_addr", 32'(bus.out_WriteAddr), 32'(m_wa));
        check("write_data", 32'(bus.out_Data),      32'(m_wd));
        check("pending",    32'(bus.out_Pending),   32'(m_pend));
        check("fifo_count", 32'(bus.out_FifoCount), 32'(q.size()));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int budget;
        m_we = 1'b0; m_wa = '0; m_wd = '0; m_pend = '0; last_accept = 1'b0;
        idle();

        // Reset held two cycles with a load offered: everything dropped.
        RST = 1'b1;
        bus.in_MemValid = 1'b1; bus.in_MemAddr = 4'd2; bus.in_MemData = 16'h5555;
        bus.in_AluValid = 1'b1; bus.in_AluAddr = 4'd6; bus.in_AluData = 16'h6666;
        tick();
        tick();
        check("rst_we",    32'(bus.out_RegWrite),  32'd0);
        check("rst_pend",  32'(bus.out_Pending),   32'd0);
        check("rst_count", 32'(bus.out_FifoCount), 32'd0);
        RST = 1'b0;
        idle();
        #1;
        check("ready_after_rst", 32'(bus.out_AluReady), 32'd1);

        // ALU bypass into an empty FIFO.
        bus.in_AluValid = 1'b1; bus.in_AluAddr = 4'd5; bus.in_AluData = 16'h1234;
        tick();
        check("bypass_we",    32'(bus.out_RegWrite),  32'd1);
        check("bypass_addr",  32'(bus.out_WriteAddr), 32'd5);
        check("bypass_data",  32'(bus.out_Data),      32'h1234);
        check("bypass_count", 32'(bus.out_FifoCount), 32'd0);
        idle();

        // Load and ALU in the same cycle: load first, ALU queued behind it.
        bus.in_MemValid = 1'b1; bus.in_MemAddr = 4'd3; bus.in_MemData = 16'h00AA;
        bus.in_AluValid = 1'b1; bus.in_AluAddr = 4'd4; bus.in_AluData = 16'h00BB;
        tick();
        check("cont1_addr",  32'(bus.out_WriteAddr), 32'd3);
        check("cont1_data",  32'(bus.out_Data),      32'h00AA);
        check("cont1_count", 32'(bus.out_FifoCount), 32'd1);
        idle();
        tick();
        check("cont2_addr",  32'(bus.out_WriteAddr), 32'd4);
        check("cont2_data",  32'(bus.out_Data),      32'h00BB);
        check("cont2_count", 32'(bus.out_FifoCount), 32'd0);

        // Six cycles of load traffic while offering ALU results 1..6 to r8.
        n = 1;
        for (int i = 0; i < 6; i++) begin
            bus.in_MemValid = 1'b1; bus.in_MemAddr = 4'd7; bus.in_MemData = 16'($urandom);
            bus.in_AluValid = 1'b1; bus.in_AluAddr = 4'd8; bus.in_AluData = 16'(n);
            tick();
            if (last_accept) n++;
        end
        check("bp_accepted", 32'(n - 1), 32'd4);
        check("bp_count",    32'(bus.out_FifoCount), 32'd4);
        bus.in_MemValid = 1'b0;
        budget = 0;
        while (n <= 6 && budget < 20) begin
            bus.in_AluValid = 1'b1; bus.in_AluAddr = 4'd8; bus.in_AluData = 16'(n);
            tick();
            if (last_accept) n++;
            budget++;
        end
        check("bp_all_accepted", 32'(n), 32'd7);
        idle();
        for (int i = 0; i < 6; i++) tick();
        check("bp_drained", 32'(bus.out_FifoCount), 32'd0);

        // Register 0: result consumed without a write, issue ignored.
        bus.in_MemValid = 1'b1; bus.in_MemAddr = 4'd0; bus.in_MemData = 16'hFFFF;
        tick();
        check("r0_we", 32'(bus.out_RegWrite), 32'd0);
        idle();
        bus.in_IssueValid = 1'b1; bus.in_IssueAddr = 4'd0;
        tick();
        check("r0_pend", 32'(bus.out_Pending[0]), 32'd0);
        idle();

        // Scoreboard set on issue, cleared on write, set wins on collision.
        bus.in_IssueValid = 1'b1; bus.in_IssueAddr = 4'd9;
        tick();
        check("sb_set", 32'(bus.out_Pending[9]), 32'd1);
        idle();
        bus.in_AluValid = 1'b1; bus.in_AluAddr = 4'd9; bus.in_AluData = 16'hC0DE;
        tick();
        check("sb_clear", 32'(bus.out_Pending[9]), 32'd0);
        idle();
        bus.in_IssueValid = 1'b1; bus.in_IssueAddr = 4'd9;
        tick();
        bus.in_AluValid = 1'b1; bus.in_AluAddr = 4'd9; bus.in_AluData = 16'hBEEF;
        tick();
        check("sb_collide", 32'(bus.out_Pending[9]), 32'd1);
        check("sb_collide_we", 32'(bus.out_RegWrite), 32'd1);
        idle();
        tick();

        // Reset mid-operation discards queued results.
        for (int i = 0; i < 3; i++) begin
            bus.in_MemValid = 1'b1; bus.in_MemAddr = 4'd1; bus.in_MemData = 16'(i);
            bus.in_AluValid = 1'b1; bus.in_AluAddr = 4'd2; bus.in_AluData = 16'(i + 16);
            tick();
        end
        idle();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        tick();
        check("midrst_we",    32'(bus.out_RegWrite),  32'd0);
        check("midrst_count", 32'(bus.out_FifoCount), 32'd0);

        // Random traffic: light then heavy load pressure, occasional reset.
        for (int i = 0; i < 500; i++) begin
            int unsigned mem_pct;
            mem_pct = (i < 250) ? 35 : 75;
            RST               = ($urandom_range(0, 79) == 0);
            bus.in_MemValid   = ($urandom_range(0, 99) < mem_pct);
            bus.in_MemAddr    = 4'($urandom);
            bus.in_MemData    = 16'($urandom);
            bus.in_AluValid   = ($urandom_range(0, 99) < 65);
            bus.in_AluAddr    = 4'($urandom);
            bus.in_AluData    = 16'($urandom);
            bus.in_IssueValid = ($urandom_range(0, 99) < 40);
            bus.in_IssueAddr  = 4'($urandom);
            tick();
        end
        RST = 1'b0;
        idle();
        for (int i = 0; i < 8; i++) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
